ct_idu_rf_prf_preg_freelist: RTL and testbench
==============================================

Name: ct_idu_rf_prf_preg_freelist

Overview:
- Physical-register free list for the integer PRF. Allocates destination pregs to rename, up to 2 per cycle, and takes back pregs released at retire, up to 2 per cycle.
- Keeps a speculative allocation head and a committed head so a pipeline flush restores every preg allocated but not committed.
- Sits in IDU rename. Its allocations select which per-preg gated registers receive writeback data.

Parameters:
- PREG_NUM, 96, total physical registers
- ARCH_NUM, 32, pregs 0..ARCH_NUM-1 mapped architecturally at reset
- PREG_W, 7, preg index width; must satisfy 2^PREG_W >= PREG_NUM
- DEPTH, PREG_NUM-ARCH_NUM (64), free-list entries; pointer width is clog2(DEPTH)

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  asynchronous active-high reset
- rn_alloc_req  in  2  allocation request; legal values 00, 01, 11
- fl_alloc_gnt  out  1  request granted this cycle (combinational)
- fl_alloc_preg0  out  PREG_W  preg at spec_head
- fl_alloc_preg1  out  PREG_W  preg at spec_head+1
- rtu_commit_num  in  2  pregs committed this cycle, 0..2
- rtu_release_vld  in  2  release valids; legal values 00, 01, 11
- rtu_release_preg0  in  PREG_W  released preg, slot 0
- rtu_release_preg1  in  PREG_W  released preg, slot 1
- rtu_flush  in  1  discard all uncommitted allocations
- fl_spec_cnt  out  clog2(DEPTH)+1  entries available to allocate
- fl_empty  out  1  fl_spec_cnt == 0
- cp0_idu_icg_en, cp0_yy_clk_en, pad_yy_icg_scan_en  in  1 each  clock-gate controls (see Optional Feature)

Behaviour:
- State:
  - array[DEPTH] of PREG_W bits
  - spec_head, commit_head, tail pointers, wrapping DEPTH-1 -> 0 (explicit wrap, no power-of-2 assumption)
  - spec_cnt, commit_cnt, 0..DEPTH
- Reset values:
  - array[i] = ARCH_NUM+i
  - all pointers = 0
  - spec_cnt = commit_cnt = DEPTH
  - so fl_spec_cnt = 64, fl_empty = 0, fl_alloc_preg0/1 = 32/33
- Allocation:
  - n_req = popcount(rn_alloc_req).
  - fl_alloc_gnt = (n_req != 0) & (spec_cnt >= n_req) & ~rtu_flush.
  - fl_alloc_preg0/1 are combinational reads of array[spec_head] and array[spec_head+1 wrapped], valid whenever spec_cnt covers them.
  - On grant, spec_head += n_req and spec_cnt -= n_req at the next edge.
  - A partial grant is never given: request 11 with spec_cnt = 1 gets gnt = 0 and no state change.
- Commit: commit_head += rtu_commit_num and commit_cnt -= rtu_commit_num. Committing more than has been allocated is illegal; flag it with a simulation assertion.
- Release:
  - Slot 0 is written to array[tail], slot 1 to array[tail+1].
  - tail += n_rel; spec_cnt += n_rel; commit_cnt += n_rel.
  - No bypass: a released preg becomes allocatable from the cycle after the write.
  - Release when commit_cnt + n_rel > DEPTH is illegal; flag it with an assertion.
- Flush:
  - Commit and release of the same cycle are applied first.
  - Then spec_head := new commit_head and spec_cnt := new commit_cnt.
  - Allocation is blocked in the flush cycle.
- Same-cycle alloc and release: both apply; spec_cnt' = spec_cnt - n_alloc + n_rel.
- Reset asserted mid-operation: all state returns to reset values asynchronously; outstanding requests are discarded.
- Invariants: spec_cnt <= commit_cnt <= DEPTH, and each preg appears at most once among the free entries.

Optional Feature:
- Macro: PRF_FREELIST_GATED_CLK_EN.
- Defined:
  - array writes are clocked by a gated_clk_cell instance.
  - Connections: clk_in = forever_cpuclk, local_en = |rtu_release_vld, global_en = cp0_yy_clk_en, module_en = cp0_idu_icg_en, external_en = 0, scan_en = pad_yy_icg_scan_en.
  - Pointers and counters stay on forever_cpuclk.
- Undefined: the array uses forever_cpuclk with a write enable, and the three icg ports are unused. Functional behaviour is identical in both builds.

Test Plan:
1. Reset release, then rn_alloc_req = 11 for one cycle -> gnt = 1, pregs 32/33. Next cycle fl_spec_cnt = 62 and preg0 = 34.
2. Allocate 63 single entries, then request 11 -> gnt = 0 and state unchanged. Request 01 -> gnt = 1, preg 95, then fl_empty = 1.
3. Allocate 6, commit 2, then rtu_flush -> next cycle spec_head = commit_head = 2, fl_spec_cnt = 62, fl_alloc_preg0 = 34.
4. From empty after 64 allocs and 64 commits, release pregs 5 and 7 with valid 11 -> same-cycle gnt = 0. Next cycle fl_spec_cnt = 2 and allocation returns 5/7.
5. Same cycle: alloc 11, release 01 (preg 3), commit 1, flush -> gnt = 0, release written at tail, spec_cnt = commit_cnt after update.
6. Wrap check: 200 cycles of random legal alloc/commit/release -> no duplicate preg handed out, and the counters match a reference model.

Source files
------------

// File: rtl/ct_idu_rf_prf_preg_freelist.sv
// Integer PRF free list: 2-wide allocate, 2-wide release, with speculative and committed heads for flush recovery.
// Optional build macro PRF_FREELIST_GATED_CLK_EN clocks the entry array through a gated_clk_cell.
module ct_idu_rf_prf_preg_freelist #(
    parameter int PREG_NUM = 96,
    parameter int ARCH_NUM = 32,
    parameter int PREG_W   = 7,
    parameter int DEPTH    = PREG_NUM - ARCH_NUM,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic [1:0]        rn_alloc_req,
    output logic              fl_alloc_gnt,
    output logic [PREG_W-1:0] fl_alloc_preg0,
    output logic [PREG_W-1:0] fl_alloc_preg1,
    input  logic [1:0]        rtu_commit_num,
    input  logic [1:0]        rtu_release_vld,
    input  logic [PREG_W-1:0] rtu_release_preg0,
    input  logic [PREG_W-1:0] rtu_release_preg1,
    input  logic              rtu_flush,
    output logic [CNT_W-1:0]  fl_spec_cnt,
    output logic              fl_empty,
    input  logic              cp0_idu_icg_en,
    input  logic              cp0_yy_clk_en,
    input  logic              pad_yy_icg_scan_en
);

    localparam int PTR_W1 = PTR_W + 1;
    localparam int CNT_W1 = CNT_W + 1;
    localparam logic [PTR_W:0] DEPTH_PTR = PTR_W1'(DEPTH);

    logic [PREG_W-1:0] array [DEPTH];
    logic [PTR_W-1:0]  spec_head;
    logic [PTR_W-1:0]  commit_head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  spec_cnt;
    logic [CNT_W-1:0]  commit_cnt;

    logic [PTR_W-1:0]  spec_head_nxt;
    logic [PTR_W-1:0]  commit_head_nxt;
    logic [PTR_W-1:0]  tail_nxt;
    logic [PTR_W-1:0]  spec_head_p1;
    logic [PTR_W-1:0]  tail_p1;
    logic [CNT_W-1:0]  spec_cnt_nxt;
    logic [CNT_W-1:0]  commit_cnt_nxt;
    logic [1:0]        n_req;
    logic [1:0]        n_rel;
    logic [1:0]        n_alloc;
    logic              array_clk;

    // Pointer increment by 0..2 with explicit wrap; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input logic [1:0] n);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + PTR_W1'(n);
        if (sum >= DEPTH_PTR)
            sum = sum - DEPTH_PTR;
        return sum[PTR_W-1:0];
    endfunction

    assign n_req   = {1'b0, rn_alloc_req[1]} + {1'b0, rn_alloc_req[0]};
    assign n_rel   = {1'b0, rtu_release_vld[1]} + {1'b0, rtu_release_vld[0]};

    // All-or-nothing grant; a flush cycle never allocates.
    assign fl_alloc_gnt = (n_req != 2'd0) && (spec_cnt >= CNT_W'(n_req)) && !rtu_flush;
    assign n_alloc      = fl_alloc_gnt ? n_req : 2'd0;

    assign spec_head_p1    = ptr_add(spec_head, 2'd1);
    assign tail_p1         = ptr_add(tail, 2'd1);
    assign commit_head_nxt = ptr_add(commit_head, rtu_commit_num);
    assign tail_nxt        = ptr_add(tail, n_rel);
    assign commit_cnt_nxt  = commit_cnt - CNT_W'(rtu_commit_num) + CNT_W'(n_rel);

    // Flush rewinds speculation to the committed view after this cycle's commit and release.
    always_comb begin
        spec_head_nxt = ptr_add(spec_head, n_alloc);
        spec_cnt_nxt  = spec_cnt - CNT_W'(n_alloc) + CNT_W'(n_rel);
        if (rtu_flush) begin
            spec_head_nxt = commit_head_nxt;
            spec_cnt_nxt  = commit_cnt_nxt;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= '0;
            spec_cnt    <= CNT_W'(DEPTH);
            commit_cnt  <= CNT_W'(DEPTH);
        end else begin
            spec_head   <= spec_head_nxt;
            commit_head <= commit_head_nxt;
            tail        <= tail_nxt;
            spec_cnt    <= spec_cnt_nxt;
            commit_cnt  <= commit_cnt_nxt;
        end
    end

`ifdef PRF_FREELIST_GATED_CLK_EN
    gated_clk_cell x_array_gated_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_idu_icg_en),
        .local_en           (|rtu_release_vld),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (array_clk)
    );
`else
    logic unused_icg;
    assign array_clk  = forever_cpuclk;
    assign unused_icg = ^{cp0_idu_icg_en, cp0_yy_clk_en, pad_yy_icg_scan_en};
`endif

    // No bypass: released pregs land in the array and are visible from the next cycle.
    always_ff @(posedge array_clk or posedge cpurst) begin
        if (cpurst) begin
            for (int i = 0; i < DEPTH; i++)
                array[i] <= PREG_W'(ARCH_NUM + i);
        end else begin
            if (rtu_release_vld[0])
                array[tail] <= rtu_release_preg0;
            if (rtu_release_vld[1])
                array[tail_p1] <= rtu_release_preg1;
        end
    end

    assign fl_alloc_preg0 = array[spec_head];
    assign fl_alloc_preg1 = array[spec_head_p1];
    assign fl_spec_cnt    = spec_cnt;
    assign fl_empty       = (spec_cnt == '0);

    a_commit_legal: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        CNT_W'(rtu_commit_num) <= (commit_cnt - spec_cnt));

    a_release_legal: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        (CNT_W1'(commit_cnt) + CNT_W1'(n_rel)) <= CNT_W1'(DEPTH));

endmodule

// File: tb/tb_ct_idu_rf_prf_preg_freelist.sv
// Randomized and directed bench for the PRF free list against a queue-based model of free pregs.
module tb_ct_idu_rf_prf_preg_freelist;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic       gnt;
    logic [6:0] p0, p1;
    logic [1:0] cnum = 2'b00;
    logic [1:0] rvld = 2'b00;
    logic [6:0] rp0 = '0, rp1 = '0;
    logic       flush = 1'b0;
    logic [6:0] spec_cnt;
    logic       empty;

    always #5 clk = ~clk;

    ct_idu_rf_prf_preg_freelist dut (
        .forever_cpuclk     (clk),
        .cpurst             (rst),
        .rn_alloc_req       (req),
        .fl_alloc_gnt       (gnt),
        .fl_alloc_preg0     (p0),
        .fl_alloc_preg1     (p1),
        .rtu_commit_num     (cnum),
        .rtu_release_vld    (rvld),
        .rtu_release_preg0  (rp0),
        .rtu_release_preg1  (rp1),
        .rtu_flush          (flush),
        .fl_spec_cnt        (spec_cnt),
        .fl_empty           (empty),
        .cp0_idu_icg_en     (1'b1),
        .cp0_yy_clk_en      (1'b1),
        .pad_yy_icg_scan_en (1'b0)
    );

    int errors = 0;
    int checks = 0;

    // Model: fifo holds the committed-free pregs in hand-out order; the first spec_off
    // of them are speculatively allocated. owned holds pregs mapped and releasable.
    int fifo[$];
    int owned[$];
    int spec_off;
    bit outst[128];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        owned.delete();
        spec_off = 0;
        for (int i = 0; i < 128; i++) outst[i] = (i < 32);
        for (int i = 0; i < 64; i++) fifo.push_back(32 + i);
        for (int i = 0; i < 32; i++) owned.push_back(i);
    endtask

    task automatic take_owned(input int p);
        int idx;
        idx = -1;
        foreach (owned[i]) if (owned[i] == p) idx = i;
        if (idx >= 0) owned.delete(idx);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req = 2'b00; cnum = 2'b00; rvld = 2'b00; flush = 1'b0;
        rst = 1'b1;
        #3;
        chk("rst_cnt", spec_cnt, 64);
        chk("rst_empty", empty, 0);
        chk("rst_preg0", p0, 32);
        chk("rst_preg1", p1, 33);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [1:0] r, input int cn, input logic [1:0] rv,
                        input int q0, input int q1, input logic fl,
                        input int eg = -1, input int e0 = -1, input int e1 = -1);
        int nreq, avail, mg, p;
        req = r; cnum = cn[1:0]; rvld = rv; rp0 = q0[6:0]; rp1 = q1[6:0]; flush = fl;
        nreq  = int'(r[0]) + int'(r[1]);
        avail = fifo.size() - spec_off;
        mg    = (nreq != 0 && avail >= nreq && !fl) ? 1 : 0;
        #2;
        chk("gnt", gnt, mg);
        if (eg >= 0) chk("gnt_dir", gnt, eg);
        if (avail >= 1) chk("preg0", p0, fifo[spec_off]);
        if (avail >= 2) chk("preg1", p1, fifo[spec_off + 1]);
        if (e0 >= 0) chk("preg0_dir", p0, e0);
        if (e1 >= 0) chk("preg1_dir", p1, e1);
        if (mg != 0) begin
            for (int k = 0; k < nreq; k++) begin
                p = fifo[spec_off + k];
                chk("dup", int'(outst[p]), 0);
                outst[p] = 1'b1;
            end
            spec_off += nreq;
        end
        for (int k = 0; k < cn; k++) owned.push_back(fifo.pop_front());
        spec_off -= cn;
        if (rv[0]) begin take_owned(q0); outst[q0] = 1'b0; fifo.push_back(q0); end
        if (rv[1]) begin take_owned(q1); outst[q1] = 1'b0; fifo.push_back(q1); end
        if (fl) begin
            for (int k = 0; k < spec_off; k++) outst[fifo[k]] = 1'b0;
            spec_off = 0;
        end
        @(posedge clk);
        #1;
        chk("spec_cnt", spec_cnt, fifo.size() - spec_off);
        chk("empty", empty, (fifo.size() == spec_off) ? 1 : 0);
    endtask

    task automatic rand_step();
        logic [1:0] r, rv;
        int cn, room, a, b, q0, q1, sel;
        sel = $urandom_range(0, 3);
        r   = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
        cn  = $urandom_range(0, (spec_off < 2) ? spec_off : 2);
        room = 64 - fifo.size();
        sel = $urandom_range(0, 2);
        rv  = 2'b00; q0 = 0; q1 = 0;
        if (sel == 2 && room >= 2 && owned.size() >= 2) rv = 2'b11;
        else if (sel >= 1 && room >= 1 && owned.size() >= 1) rv = 2'b01;
        if (rv[0]) begin
            a  = $urandom_range(0, owned.size() - 1);
            q0 = owned[a];
            if (rv[1]) begin
                b  = (a + 1 + $urandom_range(0, owned.size() - 2)) % owned.size();
                q1 = owned[b];
            end
        end
        step(r, cn, rv, q0, q1, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Basic dual allocation
        step(2'b11, 0, 2'b00, 0, 0, 1'b0, 1, 32, 33);
        chk("t1_cnt", spec_cnt, 62);
        chk("t1_preg0", p0, 34);

        // Drain to one entry, partial request refused, last single granted
        do_reset();
        repeat (63) step(2'b01, 0, 2'b00, 0, 0, 1'b0);
        chk("t2_cnt1", spec_cnt, 1);
        step(2'b11, 0, 2'b00, 0, 0, 1'b0, 0);
        chk("t2_cnt_hold", spec_cnt, 1);
        chk("t2_preg_hold", p0, 95);
        step(2'b01, 0, 2'b00, 0, 0, 1'b0, 1, 95);
        chk("t2_empty", empty, 1);

        // Flush returns uncommitted allocations
        do_reset();
        repeat (3) step(2'b11, 0, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2, 2'b00, 0, 0, 1'b0);
        step(2'b00, 0, 2'b00, 0, 0, 1'b1);
        chk("t3_cnt", spec_cnt, 62);
        chk("t3_preg0", p0, 34);

        // Release into an empty list; no same-cycle bypass
        do_reset();
        for (int i = 0; i < 32; i++) step(2'b11, (i == 0) ? 0 : 2, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2, 2'b00, 0, 0, 1'b0);
        chk("t4_empty", empty, 1);
        step(2'b11, 0, 2'b11, 5, 7, 1'b0, 0);
        chk("t4_cnt", spec_cnt, 2);
        step(2'b11, 0, 2'b00, 0, 0, 1'b0, 1, 5, 7);

        // Alloc + release + commit + flush in one cycle
        step(2'b11, 1, 2'b01, 3, 0, 1'b1, 0);
        chk("t5_cnt", spec_cnt, 2);
        step(2'b11, 0, 2'b00, 0, 0, 1'b0, 1, 7, 3);

        // Random legal traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (i == 120) do_reset();
            rand_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
